// File: rtl/enc_mux_scan.sv
// Scans eight rotary encoders (phase A, phase B, pushbutton) through an
// external 8:1 analog mux. Each channel address is held for SETTLE_CYC
// cycles before one sample cycle, so the mux output has settled and the
// synchronizer has flushed before the value is latched.
//
// state  | meaning
// SETTLE | mux address held, settle counter running
// SAMPLE | single cycle; synchronized pins latched on its exit edge
// HALT   | scanning paused by en_i low, address and outputs hold
module enc_mux_scan #(
  parameter int SETTLE_CYC = 16,  // 3..255, must be >= SYNC_W+1
  parameter int SYNC_W     = 2,   // 2..4
  parameter int PB_INV     = 1    // 1: pushbutton pin is active-low
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  output logic [2:0] sel_o,
  input  logic       mux_a_i,
  input  logic       mux_b_i,
  input  logic       mux_pb_i,
  output logic [1:0] enc_0_o,
  output logic [1:0] enc_1_o,
  output logic [1:0] enc_2_o,
  output logic [1:0] enc_3_o,
  output logic [1:0] enc_4_o,
  output logic [1:0] enc_5_o,
  output logic [1:0] enc_6_o,
  output logic [1:0] enc_7_o,
  output logic [7:0] pb_o,
  output logic       frame_o,
  output logic       valid_o
);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYC - 1);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        cnt;
  logic [SYNC_W-1:0] sync_a;
  logic [SYNC_W-1:0] sync_b;
  logic [SYNC_W-1:0] sync_pb;
  logic              a_s;
  logic              b_s;
  logic              pb_s;
  logic              do_sample;
  logic              cnt_inc;
  logic [1:0]        enc_q [8];

  // Synchronize the asynchronous mux outputs before anything looks at them.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_a  <= '0;
      sync_b  <= '0;
      sync_pb <= '0;
    end else begin
      sync_a  <= {sync_a[SYNC_W-2:0], mux_a_i};
      sync_b  <= {sync_b[SYNC_W-2:0], mux_b_i};
      sync_pb <= {sync_pb[SYNC_W-2:0], mux_pb_i};
    end
  end

  assign a_s  = sync_a[SYNC_W-1];
  assign b_s  = sync_b[SYNC_W-1];
  assign pb_s = (PB_INV != 0) ? ~sync_pb[SYNC_W-1] : sync_pb[SYNC_W-1];

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_SETTLE;
    else          state <= state_nxt;
  end

  // Next-state decode; a sample in progress always completes before halting.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SETTLE: begin
        if (!en_i)                 state_nxt = ST_HALT;
        else if (cnt == CNT_LAST)  state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: state_nxt = en_i ? ST_SETTLE : ST_HALT;
      ST_HALT:   if (en_i) state_nxt = ST_SETTLE;
      default:   state_nxt = ST_SETTLE;
    endcase
  end

  // Per-state control strobes for the counter and the sample datapath.
  always_comb begin
    do_sample = (state == ST_SAMPLE);
    cnt_inc   = (state == ST_SETTLE) && en_i && (cnt != CNT_LAST);
  end

  // Settle counter; any exit from counting (sample, halt, resume) restarts at 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     cnt <= 8'd0;
    else if (cnt_inc) cnt <= cnt + 8'd1;
    else              cnt <= 8'd0;
  end

  // Latch the addressed channel, advance the mux address, flag frame end.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 8; i++) enc_q[i] <= 2'b00;
      pb_o    <= 8'h00;
      sel_o   <= 3'd0;
      frame_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      frame_o <= 1'b0;
      if (do_sample) begin
        enc_q[sel_o] <= {b_s, a_s};
        pb_o[sel_o]  <= pb_s;
        sel_o        <= sel_o + 3'd1;
        if (sel_o == 3'd7) begin
          frame_o <= 1'b1;
          valid_o <= 1'b1;
        end
      end
    end
  end

  assign enc_0_o = enc_q[0];
  assign enc_1_o = enc_q[1];
  assign enc_2_o = enc_q[2];
  assign enc_3_o = enc_q[3];
  assign enc_4_o = enc_q[4];
  assign enc_5_o = enc_q[5];
  assign enc_6_o = enc_q[6];
  assign enc_7_o = enc_q[7];

endmodule

// File: tb/tb_enc_mux_scan.sv
// Bench for enc_mux_scan with SETTLE_CYC=4, SYNC_W=2, PB_INV=1.
// A reference model tracks scan progress as a count of consecutive enabled
// edges and delays pin values by SYNC_W edges; the DUT is compared to it on
// every falling edge. Directed scenarios add literal expectations.
module tb_enc_mux_scan;
  localparam int SC = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pin_a = 1'b0;
  logic pin_b = 1'b0;
  logic pin_pb = 1'b0;
  logic [2:0] sel;
  logic [1:0] enc_w [8];
  logic [7:0] pb;
  logic frame;
  logic valid;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mode = 0;
  logic [1:0] tab_ab [8];
  logic       tab_pb [8];

  // reference model state
  int m_run;
  int m_need;
  int m_ch;
  logic [1:0] m_enc [8];
  logic [7:0] m_pb;
  logic m_frame;
  logic m_valid;
  logic [2:0] m_hist [$];

  enc_mux_scan #(.SETTLE_CYC(SC), .SYNC_W(SW), .PB_INV(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .sel_o(sel),
    .mux_a_i(pin_a), .mux_b_i(pin_b), .mux_pb_i(pin_pb),
    .enc_0_o(enc_w[0]), .enc_1_o(enc_w[1]), .enc_2_o(enc_w[2]), .enc_3_o(enc_w[3]),
    .enc_4_o(enc_w[4]), .enc_5_o(enc_w[5]), .enc_6_o(enc_w[6]), .enc_7_o(enc_w[7]),
    .pb_o(pb), .frame_o(frame), .valid_o(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0;
    m_need = SC + 1;
    m_ch = 0;
    for (int i = 0; i < 8; i++) m_enc[i] = 2'b00;
    m_pb = 8'h00;
    m_frame = 1'b0;
    m_valid = 1'b0;
    m_hist.delete();
    for (int i = 0; i < SW; i++) m_hist.push_back(3'b000);
  endtask

  // A sample happens on the edge after m_need-1 enabled edges; a resume from
  // a halt costs one extra edge because the first enabled edge only leaves HALT.
  task automatic model_step();
    logic [2:0] s;
    s = m_hist.pop_front();
    m_hist.push_back({pin_pb, pin_b, pin_a});
    m_frame = 1'b0;
    if (m_run == m_need - 1) begin
      m_enc[m_ch] = s[1:0];
      m_pb[m_ch]  = ~s[2];
      if (m_ch == 7) begin
        m_frame = 1'b1;
        m_valid = 1'b1;
      end
      m_ch  = (m_ch + 1) % 8;
      m_run = 0;
      m_need = en ? SC + 1 : SC + 2;
    end else if (en) begin
      m_run++;
    end else begin
      m_run = 0;
      m_need = SC + 2;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // compare DUT against the model every cycle
  initial begin
    forever begin
      @(negedge clk);
      check("sel", int'(sel), m_ch);
      for (int i = 0; i < 8; i++) check($sformatf("enc%0d", i), int'(enc_w[i]), int'(m_enc[i]));
      check("pb", int'(pb), int'(m_pb));
      check("frame", int'(frame), int'(m_frame));
      check("valid", int'(valid), int'(m_valid));
    end
  end

  // mux pins follow the current address
  initial begin
    forever begin
      @(negedge clk);
      if (mode == 0) begin
        pin_a  = sel[0];
        pin_b  = sel[1];
        pin_pb = ~sel[2];
      end else begin
        pin_a  = tab_ab[sel][0];
        pin_b  = tab_ab[sel][1];
        pin_pb = tab_pb[sel];
        if ($urandom % 8 == 0) pin_a = 1'($urandom % 2);
        if ($urandom % 8 == 0) pin_b = 1'($urandom % 2);
      end
    end
  end

  initial begin
    int nfr;
    int ft [3];
    logic [1:0] enc_or;
    nfr = 0;
    rst_n = 1'b0;
    en = 1'b1;
    mode = 0;
    repeat (2) @(negedge clk);
    check("rst_sel", int'(sel), 0);
    check("rst_pb", int'(pb), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_frame", int'(frame), 0);
    rst_n = 1'b1;

    // continuous run: channel every 5 edges, frame every 40
    for (int c = 1; c <= 142; c++) begin
      @(negedge clk);
      if (frame) begin
        if (nfr < 3) ft[nfr] = c;
        nfr++;
      end
      if (c == 4) check("sel_before_first_sample", int'(sel), 0);
      if (c == 5) check("sel_after_first_sample", int'(sel), 1);
      if (c == 39) check("valid_before_frame", int'(valid), 0);
      if (c == 40) begin
        check("enc5_frame1", int'(enc_w[5]), 1);
        check("enc6_frame1", int'(enc_w[6]), 2);
        check("pb_frame1", int'(pb), 8'hF0);
        check("frame_at_40", int'(frame), 1);
        check("valid_at_40", int'(valid), 1);
      end
      if (c == 41) check("frame_one_cycle", int'(frame), 0);
    end
    check("frame_count", nfr, 3);
    check("first_frame_cycle", ft[0], 40);
    check("frame_gap1", ft[1] - ft[0], 40);
    check("frame_gap2", ft[2] - ft[1], 40);

    // halt at counter=2 on channel 4, ten cycles, then resume
    check("sel_before_halt", int'(sel), 4);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("sel_halt", int'(sel), 4);
    end
    en = 1'b1;
    // SAMPLE occupies the 5th cycle after en returns; latch on its exit edge
    repeat (5) @(negedge clk);
    check("sel_resume_5", int'(sel), 4);
    @(negedge clk);
    check("sel_resume_6", int'(sel), 5);
    repeat (5) @(negedge clk);
    check("sel_at_6", int'(sel), 6);
    check("valid_before_rst", int'(valid), 1);

    // asynchronous reset mid-frame
    #1 rst_n = 1'b0;
    #1;
    enc_or = 2'b00;
    for (int i = 0; i < 8; i++) enc_or = enc_or | enc_w[i];
    check("async_rst_sel", int'(sel), 0);
    check("async_rst_enc", int'(enc_or), 0);
    check("async_rst_pb", int'(pb), 0);
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_frame", int'(frame), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 5) check("post_rst_sel", int'(sel), 1);
      if (c == 39) check("post_rst_valid_39", int'(valid), 0);
      if (c == 40) check("post_rst_valid_40", int'(valid), 1);
    end

    // randomized pins, enable gaps and occasional resets
    for (int i = 0; i < 8; i++) begin
      tab_ab[i] = 2'($urandom % 4);
      tab_pb[i] = 1'($urandom % 2);
    end
    mode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (en) en = ($urandom % 25) != 0;
      else    en = ($urandom % 4) == 0;
      if ($urandom % 4 == 0) begin
        int k;
        k = int'($urandom % 8);
        tab_ab[k] = 2'($urandom % 4);
        tab_pb[k] = 1'($urandom % 2);
      end
      if ($urandom % 1000 == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/enc_mux_scan.md
ENC_MUX_SCAN -- requirements
Module: enc_mux_scan

Interface
REQ-001 Parameter SETTLE_CYC, default 16: cycles sel_o is held stable before each sample; legal range 3..255.
REQ-002 Parameter SYNC_W, default 2: synchronizer depth on the mux inputs; legal range 2..4; SETTLE_CYC SHALL be >= SYNC_W+1.
REQ-003 Parameter PB_INV, default 1: 1 = pushbutton pin active-low, inverted so pb_o is 1 when pressed.
REQ-004 clk_i  in  1  clock; one clock domain; reset is asynchronous and active-low.
REQ-005 rst_n_i  in  1  async reset, active low.
REQ-006 en_i  in  1  scan enable, active high.
REQ-007 sel_o  out  3  external 8:1 mux channel address.
REQ-008 mux_a_i, mux_b_i, mux_pb_i  in  1 each  shared mux outputs (encoder phase A, phase B, pushbutton); asynchronous.
REQ-009 enc_0_o .. enc_7_o  out  2 each  held encoder phases per channel, {B,A}.
REQ-010 pb_o  out  8  held pushbutton state per channel, bit n = channel n.
REQ-011 frame_o  out  1  one-cycle pulse when channel 7 is sampled.
REQ-012 valid_o  out  1  high once the first full frame after reset is complete.

Function
REQ-013 All three mux inputs SHALL pass through a SYNC_W-flop synchronizer before any use.
REQ-014 FSM states: SETTLE, SAMPLE, HALT.
REQ-015 SETTLE: settle counter increments from 0 each cycle; when the count reaches SETTLE_CYC-1 with en_i high, next state is SAMPLE.
REQ-016 SAMPLE (exactly one cycle): on the exiting edge, latch the synchronized A, B and (PB_INV-adjusted) pb into the channel indexed by sel_o, increment sel_o modulo 8 (7 -> 0), clear the counter, and go to SETTLE (en_i high) or HALT (en_i low).
REQ-017 Channel period is SETTLE_CYC+1 cycles; frame period is 8*(SETTLE_CYC+1) cycles.
REQ-018 frame_o SHALL be high during the cycle following the SAMPLE of channel 7, for one cycle only.
REQ-019 valid_o SHALL rise together with the first frame_o after reset and stay high until reset.
REQ-020 en_i low in SETTLE: go to HALT next cycle and clear the counter; sel_o, enc_*_o and pb_o hold.
REQ-021 en_i low during SAMPLE: the sample still completes, then HALT.
REQ-022 HALT: stay while en_i low; on en_i high go to SETTLE with counter 0 and the current sel_o (settle restarts in full; no channel is skipped).
REQ-023 Only the addressed channel's outputs change on a SAMPLE; all other channels hold.
REQ-024 sel_o SHALL change only on the SAMPLE exit edge, so the mux address is stable for at least SETTLE_CYC cycles before each sample.

Reset
REQ-025 rst_n_i low SHALL asynchronously force: state SETTLE, counter 0, sel_o 0, all enc_*_o 2'b00, pb_o 8'h00, frame_o 0, valid_o 0, synchronizer flops 0.
REQ-026 After rst_n_i deasserts, scanning begins on the first clock edge when en_i is high; reset asserted mid-frame discards partial-frame progress and restarts at channel 0.

Verification
REQ-027 SETTLE_CYC=4, en_i=1, mux pins tied to a per-sel model (ch n: A=n[0], B=n[1], pb pin=~n[2]) -> sel_o steps 0..7 every 5 cycles; after 40 cycles enc_5_o=2'b01, enc_6_o=2'b10, pb_o=8'hF0, frame_o pulses once, valid_o=1.
REQ-028 Phase A of channel 3 toggles while sel_o=2 only -> enc_3_o unchanged; a toggle held through the channel-3 settle window appears at the next channel-3 sample.
REQ-029 Pin change 1 cycle before the channel-2 sample edge (SYNC_W=2) -> old value latched; same change 3 cycles before the edge -> new value latched.
REQ-030 en_i low at counter=2 on sel_o=4 for 10 cycles, then high -> sel_o stays 4, no output changes, channel 4 samples exactly 5 cycles after en_i returns.
REQ-031 rst_n_i pulsed low at sel_o=6 after valid_o=1 -> all outputs 0 immediately, without a clock edge; sel_o restarts at 0; valid_o returns high only after a full 40-cycle frame.
REQ-032 Continuous run over 3 frames -> frame_o pulses are exactly 40 cycles apart and sel_o wraps 7 -> 0 without a gap cycle.
